// File: rtl/mau_pkg.sv
// Shared types and helpers for the load/store sequencer.
// Misalignment trapping is enabled by defining MAU_MISALIGN_CHECK_EN.
package mau_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    function automatic logic [3:0] size_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic [2:0] low_mask(input logic [2:0] f3);
        return 3'(size_bytes(f3) - 4'd1);
    endfunction

    function automatic logic is_aligned(input logic [2:0] f3,
                                        input logic [2:0] off);
        return (off & low_mask(f3)) == 3'b000;
    endfunction

    // Stores have no unsigned variants, so funct3[2] is illegal for them.
    function automatic logic is_legal(input logic       write,
                                      input logic [2:0] f3);
        return write ? !f3[2] : (f3 != 3'b111);
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response and memory pin bundle for mem_access_unit.
// slave = the unit; master = datapath plus memory side.
interface mem_access_unit_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] WriteData;
    logic [DATA_W-1:0] ReadData;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  ReadData,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output MemRead, MemWrite, Address, WriteData
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        output ReadData,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  MemRead, MemWrite, Address, WriteData
    );
endinterface

// File: rtl/mau_lane_align.sv
// Byte-lane extract/extend for loads and lane merge for stores.
// Offsets arrive already naturally aligned for the access size.
module mau_lane_align
    import mau_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] i_dword,
    input  logic [2:0]        i_off,
    input  logic [2:0]        i_f3,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_load,
    output logic [DATA_W-1:0] o_merged
);
    logic [5:0]        w_sh;
    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_mask;

    assign w_sh      = {i_off, 3'b000};
    assign w_shifted = i_dword >> w_sh;

    always_comb begin
        o_load = '0;
        case (i_f3)
            F3_B:  o_load = {{56{w_shifted[7]}},  w_shifted[7:0]};
            F3_H:  o_load = {{48{w_shifted[15]}}, w_shifted[15:0]};
            F3_W:  o_load = {{32{w_shifted[31]}}, w_shifted[31:0]};
            F3_D:  o_load = w_shifted;
            F3_BU: o_load = {56'd0, w_shifted[7:0]};
            F3_HU: o_load = {48'd0, w_shifted[15:0]};
            F3_WU: o_load = {32'd0, w_shifted[31:0]};
            default: o_load = '0;
        endcase
    end

    always_comb begin
        w_mask = '1;
        case (i_f3[1:0])
            2'b00:   w_mask = 64'h0000_0000_0000_00FF;
            2'b01:   w_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   w_mask = 64'h0000_0000_FFFF_FFFF;
            default: w_mask = '1;
        endcase
    end

    assign o_merged = (i_dword & ~(w_mask << w_sh))
                    | ((i_wdata & w_mask) << w_sh);
endmodule

// File: rtl/mem_access_unit.sv
// RV64 load/store sequencer with read-modify-write for sub-dword stores.
// Define MAU_MISALIGN_CHECK_EN to trap misaligned accesses instead of aligning.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
) (
    input logic              clk,
    input logic              reset,
    mem_access_unit_if.slave bus
);
    state_t            r_state;
    logic              r_ready;
    logic              r_resp_valid;
    logic              r_err;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_write;
    logic [2:0]        r_f3;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_data;

    logic              w_bad;
    logic [ADDR_W-1:0] w_eff_addr;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_merged;

`ifdef MAU_MISALIGN_CHECK_EN
    assign w_bad = !is_legal(bus.req_write, bus.req_funct3)
                || !is_aligned(bus.req_funct3, bus.req_addr[2:0]);
    assign w_eff_addr = bus.req_addr;
`else
    assign w_bad = !is_legal(bus.req_write, bus.req_funct3);
    // Silently round down to the natural boundary of the access size.
    assign w_eff_addr = {bus.req_addr[ADDR_W-1:3],
                         bus.req_addr[2:0] & ~low_mask(bus.req_funct3)};
`endif

    mau_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane (
        .i_dword  (r_data),
        .i_off    (r_addr[2:0]),
        .i_f3     (r_f3),
        .i_wdata  (r_wdata),
        .o_load   (w_load),
        .o_merged (w_merged)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_ready      <= 1'b1;
            r_resp_valid <= 1'b0;
            r_err        <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_write      <= 1'b0;
            r_f3         <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_data       <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_ready <= 1'b0;
                        r_write <= bus.req_write;
                        r_f3    <= bus.req_funct3;
                        r_addr  <= w_eff_addr;
                        r_wdata <= bus.req_wdata;
                        // SD merges against zero, giving req_wdata unchanged.
                        r_data  <= '0;
                        if (w_bad) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_err        <= 1'b1;
                        end else if (!bus.req_write
                                     || bus.req_funct3 != F3_D) begin
                            r_state    <= RD;
                            r_mem_read <= 1'b1;
                        end else begin
                            r_state     <= WR;
                            r_mem_write <= 1'b1;
                        end
                    end
                end
                RD: begin
                    r_mem_read <= 1'b0;
                    r_data     <= bus.ReadData;
                    if (r_write) begin
                        r_state     <= WR;
                        r_mem_write <= 1'b1;
                    end else begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                    end
                end
                WR: begin
                    r_mem_write  <= 1'b0;
                    r_state      <= RESP;
                    r_resp_valid <= 1'b1;
                end
                RESP: begin
                    r_resp_valid <= 1'b0;
                    r_err        <= 1'b0;
                    r_ready      <= 1'b1;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = r_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_err;
    assign bus.resp_rdata = (r_resp_valid && !r_err && !r_write)
                          ? w_load : '0;
    assign bus.MemRead    = r_mem_read;
    assign bus.MemWrite   = r_mem_write;
    assign bus.Address    = (r_mem_read || r_mem_write)
                          ? {r_addr[ADDR_W-1:3], 3'b000} : '0;
    assign bus.WriteData  = r_mem_write ? w_merged : '0;
endmodule
